imem_port_arbiter: RTL and testbench

Arbitrates one single-ported, synchronous-read instruction memory between the fetch stage (instruction requests) and the memory stage (loads/stores into instruction space). Data accesses win by default, and a starvation counter guarantees fetch progress. The block drives the fetch stall, routes the one-cycle-latency read data back to its owner, and drops fetch responses cancelled by a branch or jump redirect.

---
 rtl/imem_port_arbiter_if.sv | 60 ++++++
 rtl/imem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Bundle of the fetch, data and memory-side signals around the
//               instruction-memory port arbiter.
//               slave  - the arbiter's view (takes requests, drives grants,
//                        responses and the memory port).
//               master - the environment's view (fetch stage, memory stage
//                        and the memory macro's read-data return).
//   Fetch  : f_req, f_addr, flush -> ; <- f_gnt, f_rvalid, f_rdata, stall_fetch
//   Data   : d_req, d_we, d_addr, d_wdata -> ; <- d_gnt, d_rvalid, d_rdata
//   Memory : <- mem_en, mem_we, mem_addr, mem_wdata ; mem_rdata ->
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_port_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 14
);
    // fetch side
    logic              f_req;
    logic [XLEN-1:0]   f_addr;
    logic              flush;
    logic              f_gnt;
    logic              f_rvalid;
    logic [XLEN-1:0]   f_rdata;
    logic              stall_fetch;
    // data side
    logic              d_req;
    logic [3:0]        d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;
    // memory side
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  f_req, f_addr, flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata, stall_fetch,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, stall_fetch,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one single-ported, synchronous-read instruction memory
//               between instruction fetch and data accesses. Data wins ties
//               unless fetch has been denied MAX_STARVE cycles in a row.
//               Read data returns one cycle after the grant and is steered to
//               the owner recorded at grant time; fetch responses are dropped
//               when a redirect (flush) is seen in the grant or response cycle.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset; forces all control
//                      outputs low and discards any read in flight
//               bus  - imem_port_arbiter_if.slave (fetch, data, memory)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 14,
    parameter int MAX_STARVE = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    imem_port_arbiter_if.slave     bus
);

    localparam logic [3:0] c_max_starve = 4'(MAX_STARVE);

    // Who the memory's read data belongs to in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e      owner_q, owner_d;
    logic        cancel_q, cancel_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic            w_f_gnt;
    logic            w_d_gnt;
    logic [XLEN-1:0] w_gnt_addr;
    logic            w_unused_addr_bits;

    // ------------------------------------------------------------------
    // Grant: data wins a tie until fetch has starved long enough.
    // Nothing is granted while in reset so no access reaches the memory.
    // ------------------------------------------------------------------
    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            if (bus.f_req && bus.d_req) begin
                if (starve_cnt_q == c_max_starve) begin
                    w_f_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b1;
                end
            end else begin
                w_f_gnt = bus.f_req;
                w_d_gnt = bus.d_req;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state: starvation counter, read owner and fetch-cancel flag.
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = 4'd0;
        owner_d      = OWN_NONE;
        cancel_d     = 1'b0;

        if (bus.f_req && !w_f_gnt) begin
            starve_cnt_d = (starve_cnt_q == c_max_starve) ? starve_cnt_q
                                                          : starve_cnt_q + 4'd1;
        end

        if (w_f_gnt) begin
            owner_d  = OWN_FETCH;
            // A redirect in the grant cycle makes this fetch stale already.
            cancel_d = bus.flush;
        end else if (w_d_gnt && (bus.d_we == 4'b0000)) begin
            owner_d  = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            owner_q      <= OWN_NONE;
            cancel_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            cancel_q     <= cancel_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory port: word address taken from the granted byte address.
    // ------------------------------------------------------------------
    assign w_gnt_addr         = w_d_gnt ? bus.d_addr : bus.f_addr;
    assign w_unused_addr_bits = ^{w_gnt_addr[XLEN-1:ADDR_W+2], w_gnt_addr[1:0]};

    assign bus.mem_en    = w_f_gnt | w_d_gnt;
    assign bus.mem_addr  = w_gnt_addr[ADDR_W+1:2];
    assign bus.mem_we    = w_d_gnt ? bus.d_we : 4'b0000;
    assign bus.mem_wdata = bus.d_wdata;

    assign bus.f_gnt       = w_f_gnt;
    assign bus.d_gnt       = w_d_gnt;
    assign bus.stall_fetch = bus.f_req & ~w_f_gnt & ~rst;

    // ------------------------------------------------------------------
    // Response steering. A flush in the response cycle also kills a fetch
    // response; data responses are never cancelled.
    // ------------------------------------------------------------------
    assign bus.d_rvalid = ~rst & (owner_q == OWN_DATA);
    assign bus.f_rvalid = ~rst & (owner_q == OWN_FETCH) & ~cancel_q & ~bus.flush;
    assign bus.f_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Self-checking bench for imem_port_arbiter. Directed scenarios
//               followed by randomized traffic compared against a
//               transaction-level reference model and a reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int ADDR_W     = 14;
    localparam int MAX_STARVE = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    imem_port_arbiter #(
        .XLEN       (XLEN),
        .ADDR_W     (ADDR_W),
        .MAX_STARVE (MAX_STARVE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory macro: synchronous read, byte-enable write; garbage when idle.
    logic [31:0] mem_arr [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we == 4'b0000) begin
            bus.mem_rdata <= mem_arr[bus.mem_addr];
        end else begin
            bus.mem_rdata <= $urandom;
        end
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem_arr[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: arbitration rule, one pending read, own copy of memory.
    logic [31:0] ref_mem [DEPTH];
    int          m_denied = 0;      // consecutive cycles fetch asked and lost
    bit          m_pv = 0;          // a read is in flight
    bit          m_pf = 0;          // ...and it belongs to fetch
    bit          m_pc = 0;          // ...and it was flushed at grant
    logic [31:0] m_pd;              // data it must return

    wire m_fg = !rst && bus.f_req && (!bus.d_req || m_denied >= MAX_STARVE);
    wire m_dg = !rst && bus.d_req && !m_fg;

    always @(posedge clk) begin
        if (rst) begin
            m_denied <= 0;
            m_pv     <= 1'b0;
            m_pf     <= 1'b0;
            m_pc     <= 1'b0;
        end else begin
            m_pv <= m_fg || (m_dg && bus.d_we == 4'b0000);
            m_pf <= m_fg;
            m_pc <= m_fg && bus.flush;
            m_pd <= m_fg ? ref_mem[bus.f_addr[ADDR_W+1:2]] : ref_mem[bus.d_addr[ADDR_W+1:2]];
            if (m_dg) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.d_we[b]) ref_mem[bus.d_addr[ADDR_W+1:2]][8*b +: 8] <= bus.d_wdata[8*b +: 8];
                end
            end
            if (bus.f_req && !m_fg) m_denied <= (m_denied < MAX_STARVE) ? m_denied + 1 : MAX_STARVE;
            else                    m_denied <= 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.flush   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 4'b0000;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        bus.f_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.f_gnt, bus.d_gnt, bus.mem_en, bus.stall_fetch, bus.f_rvalid,
                   bus.d_rvalid, bus.mem_we};
            checks++;
            if (got !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %b exp 0", i, got);
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        got = {bus.f_gnt, bus.d_gnt, bus.mem_en, bus.stall_fetch, bus.f_rvalid,
               bus.d_rvalid, bus.mem_we};
        checks++;
        if (got !== 10'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b exp 0", got);
        end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        bus.f_req = 1'b1; bus.f_addr = 32'h4000_0000;
        @(negedge clk);
        checks++;
        if ({bus.f_gnt, bus.d_gnt, bus.stall_fetch, bus.f_rvalid, bus.mem_addr} !== {4'b1000, 14'h0000}) begin
            errors++;
            $display("FAIL fetch0 got gnt/stall/rv %b addr %h exp 1000 addr 0000",
                     {bus.f_gnt, bus.d_gnt, bus.stall_fetch, bus.f_rvalid}, bus.mem_addr);
        end
        next_cycle();
        bus.f_addr = 32'h4000_0004;
        @(negedge clk);
        checks++;
        if ({bus.f_gnt, bus.d_gnt, bus.stall_fetch, bus.f_rvalid, bus.mem_addr, bus.f_rdata} !==
            {4'b1001, 14'h0001, ref_mem[0]}) begin
            errors++;
            $display("FAIL fetch1 got %b addr %h data %h exp 1001 addr 0001 data %h",
                     {bus.f_gnt, bus.d_gnt, bus.stall_fetch, bus.f_rvalid}, bus.mem_addr,
                     bus.f_rdata, ref_mem[0]);
        end
        next_cycle();
        bus.f_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.f_gnt, bus.stall_fetch, bus.f_rvalid, bus.f_rdata} !== {3'b001, ref_mem[1]}) begin
            errors++;
            $display("FAIL fetch_resp2 got %b data %h exp 001 data %h",
                     {bus.f_gnt, bus.stall_fetch, bus.f_rvalid}, bus.f_rdata, ref_mem[1]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle_rvalid got %b exp 0", bus.f_rvalid);
        end
    endtask

    task automatic test_contention();
        logic [4:0] got, exp;
        bit         ef, efrv, edrv;
        next_cycle();
        bus.f_req = 1'b1; bus.f_addr = 32'h4000_0200;
        bus.d_req = 1'b1; bus.d_addr = 32'h4000_0100; bus.d_we = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ef   = (i == 4);
            efrv = (i == 5);
            edrv = (i > 0) && (i != 5);
            exp  = {ef, !ef, !ef, efrv, edrv};
            got  = {bus.f_gnt, bus.d_gnt, bus.stall_fetch, bus.f_rvalid, bus.d_rvalid};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL contention cycle %0d got fg/dg/stall/frv/drv %b exp %b", i, got, exp);
            end
            if (edrv) begin
                checks++;
                if (bus.d_rdata !== ref_mem[14'h40]) begin
                    errors++;
                    $display("FAIL contention_drdata cycle %0d got %h exp %h", i, bus.d_rdata, ref_mem[14'h40]);
                end
            end
            if (efrv) begin
                checks++;
                if (bus.f_rdata !== ref_mem[14'h80]) begin
                    errors++;
                    $display("FAIL contention_frdata cycle %0d got %h exp %h", i, bus.f_rdata, ref_mem[14'h80]);
                end
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.f_rvalid, bus.d_rvalid} !== 2'b01) begin
            errors++;
            $display("FAIL contention_tail got frv/drv %b exp 01", {bus.f_rvalid, bus.d_rvalid});
        end
    endtask

    task automatic test_store();
        logic [31:0] old;
        next_cycle();
        old = ref_mem[4];
        bus.d_req = 1'b1; bus.d_we = 4'b0011; bus.d_addr = 32'h4000_0010; bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {2'b11, 4'b0011, 14'h0004, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store got gnt/en %b we %b addr %h wdata %h exp 11 0011 0004 deadbeef",
                     {bus.d_gnt, bus.mem_en}, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_no_rvalid got %b exp 0", bus.d_rvalid);
        end
        next_cycle();
        bus.d_req = 1'b1; bus.d_addr = 32'h4000_0010;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, old[31:16], 16'hBEEF}) begin
            errors++;
            $display("FAIL store_readback got rv %b data %h exp 1 data %h",
                     bus.d_rvalid, bus.d_rdata, {old[31:16], 16'hBEEF});
        end
    endtask

    task automatic test_flush_fetch();
        next_cycle();
        bus.f_req = 1'b1; bus.f_addr = 32'h4000_0020;
        @(negedge clk);
        checks++;
        if (bus.f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_fetch_gnt got %b exp 1", bus.f_gnt);
        end
        next_cycle();
        bus.flush = 1'b1; bus.f_addr = 32'h4000_0024;
        @(negedge clk);
        checks++;
        if ({bus.f_gnt, bus.f_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_resp_cycle got fg/frv %b exp 10", {bus.f_gnt, bus.f_rvalid});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_grant_cycle_cancel got %b exp 0", bus.f_rvalid);
        end
    endtask

    task automatic test_flush_data();
        next_cycle();
        bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h4000_0030;
        next_cycle();
        idle_inputs();
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.f_rvalid, bus.d_rdata} !== {2'b10, ref_mem[12]}) begin
            errors++;
            $display("FAIL flush_data got drv/frv %b data %h exp 10 data %h",
                     {bus.d_rvalid, bus.f_rvalid}, bus.d_rdata, ref_mem[12]);
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] exp;
        next_cycle();
        bus.f_req = 1'b1; bus.f_addr = 32'h4000_0040;
        bus.d_req = 1'b1; bus.d_addr = 32'h4000_0050; bus.d_we = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.f_gnt, bus.d_gnt} !== 2'b01) begin
                errors++;
                $display("FAIL rst_mid_pre cycle %0d got fg/dg %b exp 01", i, {bus.f_gnt, bus.d_gnt});
            end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.f_rvalid, bus.mem_en, bus.stall_fetch, bus.f_gnt, bus.d_gnt} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_read got drv/frv/en/stall/fg/dg %b exp 000000",
                     {bus.d_rvalid, bus.f_rvalid, bus.mem_en, bus.stall_fetch, bus.f_gnt, bus.d_gnt});
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp = (i == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.f_gnt, bus.d_gnt} !== exp) begin
                errors++;
                $display("FAIL rst_starve_cleared cycle %0d got fg/dg %b exp %b", i, {bus.f_gnt, bus.d_gnt}, exp);
            end
            if (i == 0) begin
                checks++;
                if ({bus.f_rvalid, bus.d_rvalid} !== 2'b00) begin
                    errors++;
                    $display("FAIL rst_no_late_rvalid got %b exp 00", {bus.f_rvalid, bus.d_rvalid});
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [9:0]        got, exp;
        logic              efg, edg, efrv, edrv;
        logic [XLEN-1:0]   a;
        logic [ADDR_W-1:0] ea;
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            rst         = ($urandom_range(0, 99) < 3);
            bus.f_req   = ($urandom_range(0, 99) < 70);
            bus.d_req   = ($urandom_range(0, 99) < 50);
            bus.d_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            bus.f_addr  = $urandom;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.flush   = ($urandom_range(0, 99) < 15);
            @(negedge clk);
            efg  = !rst && bus.f_req && (!bus.d_req || m_denied >= MAX_STARVE);
            edg  = !rst && bus.d_req && !efg;
            efrv = !rst && m_pv && m_pf && !m_pc && !bus.flush;
            edrv = !rst && m_pv && !m_pf;
            exp  = {efg, edg, efg | edg, !rst && bus.f_req && !efg, efrv, edrv,
                    edg ? bus.d_we : 4'b0000};
            got  = {bus.f_gnt, bus.d_gnt, bus.mem_en, bus.stall_fetch, bus.f_rvalid,
                    bus.d_rvalid, bus.mem_we};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_ctrl n=%0d got fg/dg/en/stall/frv/drv/we %b exp %b", n, got, exp);
            end
            if (efg || edg) begin
                a  = efg ? bus.f_addr : bus.d_addr;
                ea = a[ADDR_W+1:2];
                checks++;
                if ({bus.mem_addr, bus.mem_wdata} !== {ea, bus.d_wdata}) begin
                    errors++;
                    $display("FAIL rand_mem n=%0d got addr %h wdata %h exp addr %h wdata %h",
                             n, bus.mem_addr, bus.mem_wdata, ea, bus.d_wdata);
                end
            end
            if (efrv) begin
                checks++;
                if (bus.f_rdata !== m_pd) begin
                    errors++;
                    $display("FAIL rand_frdata n=%0d got %h exp %h", n, bus.f_rdata, m_pd);
                end
            end
            if (edrv) begin
                checks++;
                if (bus.d_rdata !== m_pd) begin
                    errors++;
                    $display("FAIL rand_drdata n=%0d got %h exp %h", n, bus.d_rdata, m_pd);
                end
            end
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] v;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            v          = $urandom;
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_fetch_only();
        test_contention();
        test_store();
        test_flush_fetch();
        test_flush_data();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
